// File: rtl/config_switch_box_pkg.sv
// Shared definitions for the configurable switch box: select codes, FSM states,
// topology selectors and helpers that locate a track's select field in the config word.
package config_switch_box_pkg;

  localparam logic [1:0] SEL_OFF      = 2'd0;
  localparam logic [1:0] SEL_STRAIGHT = 2'd1;
  localparam logic [1:0] SEL_CW       = 2'd2;
  localparam logic [1:0] SEL_CCW      = 2'd3;

  localparam int MODE_DISJOINT = 0;
  localparam int MODE_WILTON   = 1;

  // Side indices follow config order; clockwise order is t -> r -> b -> l.
  localparam int SIDE_L = 0;
  localparam int SIDE_T = 1;
  localparam int SIDE_R = 2;
  localparam int SIDE_B = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } sb_state_e;

  function automatic int side_offset(input int side, input int width);
    return 2 * width * side;
  endfunction

  function automatic int sel_offset(input int side, input int track, input int width);
    return side_offset(side, width) + 2 * track;
  endfunction

  function automatic int opposite_side(input int side);
    return (side + 2) % 4;
  endfunction

  function automatic int cw_side(input int side);
    return (side + 1) % 4;
  endfunction

  function automatic int ccw_side(input int side);
    return (side + 3) % 4;
  endfunction

endpackage

// File: rtl/config_switch_box_if.sv
// Track-side bundle of the switch box: per-side inputs, driven values, drive
// enables and configuration status, seen from the driving and the routing side.
interface config_switch_box_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] l_in, t_in, r_in, b_in;
  logic [WIDTH-1:0] l_out, t_out, r_out, b_out;
  logic [WIDTH-1:0] l_oe, t_oe, r_oe, b_oe;
  logic             cfg_valid;
  logic             cfg_err;

  modport master (
    output l_in, t_in, r_in, b_in,
    input  l_out, t_out, r_out, b_out,
    input  l_oe, t_oe, r_oe, b_oe,
    input  cfg_valid, cfg_err
  );

  modport slave (
    input  l_in, t_in, r_in, b_in,
    output l_out, t_out, r_out, b_out,
    output l_oe, t_oe, r_oe, b_oe,
    output cfg_valid, cfg_err
  );
endinterface

// File: rtl/sb_track_mux.sv
// One output track of one side: picks straight/clockwise/counter-clockwise source
// track according to its 2-bit select code and the topology.
module sb_track_mux
  import config_switch_box_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MODE  = 0,
  parameter int IDX   = 0
) (
  input  logic [1:0]       sel_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] opp_i,
  input  logic [WIDTH-1:0] cw_i,
  input  logic [WIDTH-1:0] ccw_i,
  output logic             out_o,
  output logic             oe_o
);
  // Wilton rotates the turning connections by one track; disjoint keeps the index.
  localparam int CW_IDX  = (MODE == MODE_WILTON) ? (IDX + 1) % WIDTH : IDX;
  localparam int CCW_IDX = (MODE == MODE_WILTON) ? (IDX + WIDTH - 1) % WIDTH : IDX;

  always_comb begin
    out_o = 1'b0;
    case (sel_i)
      SEL_STRAIGHT: out_o = opp_i[IDX];
      SEL_CW:       out_o = cw_i[CW_IDX];
      SEL_CCW:      out_o = ccw_i[CCW_IDX];
      default:      out_o = 1'b0;
    endcase
  end

  assign oe_o = valid_i && (sel_i != SEL_OFF);

endmodule

// File: rtl/config_switch_box.sv
// Serially programmed switch box: parity-protected shift chain, commit FSM that
// loads the active routing config only on a clean check, and per-track muxes.
module config_switch_box
  import config_switch_box_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MODE  = 0
) (
  input  logic             prog_clk,
  input  logic             prog_rst,
  input  logic             prog_en,
  input  logic             prog_in,
  input  logic             prog_rdbk,
  output logic             prog_out,
  input  logic [WIDTH-1:0] l_in,
  input  logic [WIDTH-1:0] t_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] l_out,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] l_oe,
  output logic [WIDTH-1:0] t_oe,
  output logic [WIDTH-1:0] r_oe,
  output logic [WIDTH-1:0] b_oe,
  output logic             cfg_valid,
  output logic             cfg_err
);
  localparam int N = 8 * WIDTH;

  sb_state_e      state_q, state_d;
  logic [N:0]     chain_q, chain_d;
  logic [N-1:0]   config_q, config_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      state_q  <= IDLE;
      chain_q  <= '0;
      config_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      config_q <= config_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chain_d  = chain_q;
    config_d = config_q;
    valid_d  = valid_q;
    err_d    = err_q;

    // Shifting wins over readback; the commit below still sees the pre-shift chain.
    if (prog_en) begin
      chain_d = {chain_q[N-1:0], prog_in};
    end else if (state_q == IDLE && prog_rdbk) begin
      chain_d = {^config_q, config_q};
    end

    case (state_q)
      IDLE:   if (prog_en) state_d = SHIFT;
      SHIFT:  if (!prog_en) state_d = COMMIT;
      COMMIT: begin
        if (^chain_q == 1'b0) begin
          config_d = chain_q[N-1:0];
          valid_d  = 1'b1;
          err_d    = 1'b0;
        end else begin
          err_d    = 1'b1;
        end
        state_d = prog_en ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prog_out  = chain_q[N];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  logic [3:0][WIDTH-1:0] side_in;
  logic [3:0][WIDTH-1:0] side_out;
  logic [3:0][WIDTH-1:0] side_oe;

  assign side_in = {b_in, r_in, t_in, l_in};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_side
      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_track
        sb_track_mux #(
          .WIDTH (WIDTH),
          .MODE  (MODE),
          .IDX   (gj)
        ) u_mux (
          .sel_i   (config_q[sel_offset(gi, gj, WIDTH) +: 2]),
          .valid_i (valid_q),
          .opp_i   (side_in[opposite_side(gi)]),
          .cw_i    (side_in[cw_side(gi)]),
          .ccw_i   (side_in[ccw_side(gi)]),
          .out_o   (side_out[gi][gj]),
          .oe_o    (side_oe[gi][gj])
        );
      end
    end
  endgenerate

  assign {b_out, r_out, t_out, l_out} = side_out;
  assign {b_oe, r_oe, t_oe, l_oe}     = side_oe;

endmodule

// File: tb/tb_config_switch_box.sv
// Two chained switch boxes (disjoint, then Wilton) driven by directed and random
// programming streams and compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_config_switch_box;
  import config_switch_box_pkg::*;

  localparam int W = 3;
  localparam int N = 8 * W;
  localparam int CL = N + 1;

  logic prog_clk, prog_rst, prog_en, prog_in, prog_rdbk;
  logic p0, p1;
  logic check_en, rnd_tracks;
  int   total, bad;

  config_switch_box_if #(.WIDTH(W)) sb0 ();
  config_switch_box_if #(.WIDTH(W)) sb1 ();

  assign sb1.l_in = sb0.l_in;
  assign sb1.t_in = sb0.t_in;
  assign sb1.r_in = sb0.r_in;
  assign sb1.b_in = sb0.b_in;

  config_switch_box #(.WIDTH(W), .MODE(MODE_DISJOINT)) u0 (
    .prog_clk(prog_clk), .prog_rst(prog_rst), .prog_en(prog_en), .prog_in(prog_in),
    .prog_rdbk(prog_rdbk), .prog_out(p0),
    .l_in(sb0.l_in), .t_in(sb0.t_in), .r_in(sb0.r_in), .b_in(sb0.b_in),
    .l_out(sb0.l_out), .t_out(sb0.t_out), .r_out(sb0.r_out), .b_out(sb0.b_out),
    .l_oe(sb0.l_oe), .t_oe(sb0.t_oe), .r_oe(sb0.r_oe), .b_oe(sb0.b_oe),
    .cfg_valid(sb0.cfg_valid), .cfg_err(sb0.cfg_err)
  );

  config_switch_box #(.WIDTH(W), .MODE(MODE_WILTON)) u1 (
    .prog_clk(prog_clk), .prog_rst(prog_rst), .prog_en(prog_en), .prog_in(p0),
    .prog_rdbk(prog_rdbk), .prog_out(p1),
    .l_in(sb1.l_in), .t_in(sb1.t_in), .r_in(sb1.r_in), .b_in(sb1.b_in),
    .l_out(sb1.l_out), .t_out(sb1.t_out), .r_out(sb1.r_out), .b_out(sb1.b_out),
    .l_oe(sb1.l_oe), .t_oe(sb1.t_oe), .r_oe(sb1.r_oe), .b_oe(sb1.b_oe),
    .cfg_valid(sb1.cfg_valid), .cfg_err(sb1.cfg_err)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Model: one 50-bit chain (instance 0 in the low 25 bits), a "shifting" flag
  // meaning the last edge saw prog_en=1, and a "pending" flag meaning a commit is due.
  logic [2*CL-1:0] m_chain;
  logic [N-1:0]    m_cfg   [2];
  logic            m_valid [2];
  logic            m_err   [2];
  logic            m_shifting, m_pending;

  always @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      m_chain    <= '0;
      m_shifting <= 1'b0;
      m_pending  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_cfg[k]   <= '0;
        m_valid[k] <= 1'b0;
        m_err[k]   <= 1'b0;
      end
    end else begin
      if (m_pending) begin
        for (int k = 0; k < 2; k++) begin
          if ((^m_chain[k*CL +: CL]) == 1'b0) begin
            m_cfg[k]   <= m_chain[k*CL +: N];
            m_valid[k] <= 1'b1;
            m_err[k]   <= 1'b0;
          end else begin
            m_err[k]   <= 1'b1;
          end
        end
      end
      if (prog_en)
        m_chain <= {m_chain[2*CL-2:0], prog_in};
      else if (!m_shifting && !m_pending && prog_rdbk)
        m_chain <= {^m_cfg[1], m_cfg[1], ^m_cfg[0], m_cfg[0]};
      m_pending  <= m_shifting && !prog_en;
      m_shifting <= prog_en;
    end
  end

  function automatic logic [W-1:0] model_bus(input logic [N-1:0] cfg, input logic vld,
                                              input int mode, input int side,
                                              input logic want_oe, input logic [4*W-1:0] ins);
    logic [W-1:0] r;
    int sel, src, idx;
    r = '0;
    for (int i = 0; i < W; i++) begin
      sel = int'(cfg[2*W*side + 2*i +: 2]);
      src = side;
      idx = i;
      case (sel)
        1: src = (side + 2) % 4;
        2: begin src = (side + 1) % 4; if (mode == 1) idx = (i + 1) % W; end
        3: begin src = (side + 3) % 4; if (mode == 1) idx = (i + W - 1) % W; end
        default: ;
      endcase
      if (sel != 0) r[i] = want_oe ? vld : ins[src*W + idx];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k,
                          input logic [W-1:0] lo, to, ro, bo, loe, toe, roe, boe,
                          input logic po, cv, ce);
    logic [4*W-1:0] ins;
    ins = {sb0.b_in, sb0.r_in, sb0.t_in, sb0.l_in};
    chk($sformatf("u%0d.l_out", k), 32'(lo),  32'(model_bus(m_cfg[k], m_valid[k], k, 0, 1'b0, ins)));
    chk($sformatf("u%0d.t_out", k), 32'(to),  32'(model_bus(m_cfg[k], m_valid[k], k, 1, 1'b0, ins)));
    chk($sformatf("u%0d.r_out", k), 32'(ro),  32'(model_bus(m_cfg[k], m_valid[k], k, 2, 1'b0, ins)));
    chk($sformatf("u%0d.b_out", k), 32'(bo),  32'(model_bus(m_cfg[k], m_valid[k], k, 3, 1'b0, ins)));
    chk($sformatf("u%0d.l_oe", k),  32'(loe), 32'(model_bus(m_cfg[k], m_valid[k], k, 0, 1'b1, ins)));
    chk($sformatf("u%0d.t_oe", k),  32'(toe), 32'(model_bus(m_cfg[k], m_valid[k], k, 1, 1'b1, ins)));
    chk($sformatf("u%0d.r_oe", k),  32'(roe), 32'(model_bus(m_cfg[k], m_valid[k], k, 2, 1'b1, ins)));
    chk($sformatf("u%0d.b_oe", k),  32'(boe), 32'(model_bus(m_cfg[k], m_valid[k], k, 3, 1'b1, ins)));
    chk($sformatf("u%0d.prog_out", k),  32'(po), 32'(m_chain[k*CL + N]));
    chk($sformatf("u%0d.cfg_valid", k), 32'(cv), 32'(m_valid[k]));
    chk($sformatf("u%0d.cfg_err", k),   32'(ce), 32'(m_err[k]));
  endtask

  always @(negedge prog_clk) begin
    if (check_en) begin
      cmp_inst(0, sb0.l_out, sb0.t_out, sb0.r_out, sb0.b_out,
               sb0.l_oe, sb0.t_oe, sb0.r_oe, sb0.b_oe, p0, sb0.cfg_valid, sb0.cfg_err);
      cmp_inst(1, sb1.l_out, sb1.t_out, sb1.r_out, sb1.b_out,
               sb1.l_oe, sb1.t_oe, sb1.r_oe, sb1.b_oe, p1, sb1.cfg_valid, sb1.cfg_err);
    end
  end

  task automatic cyc(input logic en, input logic din, input logic rd);
    prog_en   = en;
    prog_in   = din;
    prog_rdbk = rd;
    if (rnd_tracks) begin
      sb0.l_in = W'($urandom);
      sb0.t_in = W'($urandom);
      sb0.r_in = W'($urandom);
      sb0.b_in = W'($urandom);
    end
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_vec(input logic [2*CL-1:0] v, input int nbits);
    for (int k = 0; k < nbits; k++) cyc(1'b1, v[2*CL-1-k], 1'b0);
  endtask

  task automatic commit_wait();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_rst(input logic do_lit);
    prog_en = 1'b0;
    #2 prog_rst = 1'b1;
    #1;
    if (do_lit) begin
      chk("rst_mid.oe0",  32'({sb0.l_oe, sb0.t_oe, sb0.r_oe, sb0.b_oe}), 32'd0);
      chk("rst_mid.out0", 32'({sb0.l_out, sb0.t_out, sb0.r_out, sb0.b_out}), 32'd0);
      chk("rst_mid.oe1",  32'({sb1.l_oe, sb1.t_oe, sb1.r_oe, sb1.b_oe}), 32'd0);
      chk("rst_mid.out1", 32'({sb1.l_out, sb1.t_out, sb1.r_out, sb1.b_out}), 32'd0);
      chk("rst_mid.prog_out", 32'({p0, p1}), 32'd0);
      chk("rst_mid.status", 32'({sb0.cfg_valid, sb0.cfg_err, sb1.cfg_valid, sb1.cfg_err}), 32'd0);
    end
    @(posedge prog_clk);
    #2 prog_rst = 1'b0;
    @(posedge prog_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CL-1:0] rb;
    total = 0; bad = 0;
    check_en = 1'b0; rnd_tracks = 1'b0;
    prog_rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0; prog_rdbk = 1'b0;
    sb0.l_in = '0; sb0.t_in = '0; sb0.r_in = '0; sb0.b_in = '0;
    #2 prog_rst = 1'b1;
    repeat (2) @(posedge prog_clk);
    #3 prog_rst = 1'b0;
    @(posedge prog_clk);
    #1;
    check_en = 1'b1;

    chk("reset.valid", 32'(sb0.cfg_valid), 32'd0);
    chk("reset.prog_out", 32'(p1), 32'd0);
    chk("reset.l_oe", 32'(sb0.l_oe), 32'd0);
    chk("reset.err", 32'(sb1.cfg_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // Instance 1 (Wilton) gets 24'h000080, instance 0 (disjoint) gets 24'h000001.
    shift_vec({1'b1, 24'h000080, 1'b1, 24'h000001}, 2*CL);
    cyc(1'b0, 1'b0, 1'b0);
    chk("latency.valid_early", 32'(sb0.cfg_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("c1.valid0", 32'(sb0.cfg_valid), 32'd1);
    chk("c1.l_oe0", 32'(sb0.l_oe), 32'b001);
    chk("c1.valid1", 32'(sb1.cfg_valid), 32'd1);
    chk("c1.t_oe1", 32'(sb1.t_oe), 32'b001);
    sb0.r_in = 3'b001; #1 chk("c1.l_out0_hi", 32'(sb0.l_out[0]), 32'd1);
    sb0.r_in = 3'b110; #1 chk("c1.l_out0_lo", 32'(sb0.l_out[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    sb0.r_in = 3'b010; #1 chk("c1.t_out1_hi", 32'(sb1.t_out[0]), 32'd1);
    sb0.r_in = 3'b101; #1 chk("c1.t_out1_lo", 32'(sb1.t_out[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    shift_vec({1'b0, 24'h000080, 1'b0, 24'h000001}, 2*CL);
    commit_wait();
    chk("perr.err0", 32'(sb0.cfg_err), 32'd1);
    chk("perr.valid0", 32'(sb0.cfg_valid), 32'd1);
    chk("perr.l_oe0", 32'(sb0.l_oe), 32'b001);
    chk("perr.err1", 32'(sb1.cfg_err), 32'd1);
    chk("perr.t_oe1", 32'(sb1.t_oe), 32'b001);

    shift_vec({1'b0, 24'h0000C0, 1'b0, 24'h00A5C3}, 2*CL);
    commit_wait();
    chk("c3.err0", 32'(sb0.cfg_err), 32'd0);
    chk("c3.t_oe1", 32'(sb1.t_oe), 32'b001);
    sb0.l_in = 3'b100; #1 chk("c3.t_out1_hi", 32'(sb1.t_out[0]), 32'd1);
    sb0.l_in = 3'b011; #1 chk("c3.t_out1_lo", 32'(sb1.t_out[0]), 32'd0);

    cyc(1'b0, 1'b0, 1'b1);
    rb = {1'b0, 24'h00A5C3};
    for (int k = 0; k < CL; k++) begin
      chk($sformatf("rdbk.bit%0d", k), 32'(p0), 32'(rb[CL-1-k]));
      cyc(1'b1, 1'b0, 1'b0);
    end
    commit_wait();

    shift_vec({1'b1, 24'h000080, 1'b1, 24'h000001}, 12);
    pulse_rst(1'b1);
    commit_wait();
    chk("post_rst.valid0", 32'(sb0.cfg_valid), 32'd0);
    chk("post_rst.valid1", 32'(sb1.cfg_valid), 32'd0);

    rnd_tracks = 1'b1;
    repeat (120) begin
      int len, idle;
      len  = $urandom_range(1, 60);
      idle = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) cyc(1'b1, 1'($urandom), 1'b0);
      for (int k = 0; k < idle; k++) cyc(1'b0, 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 29) == 0) pulse_rst(1'b0);
    end
    commit_wait();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_switch_box.md
CONFIG_SWITCH_BOX -- requirements
Module: config_switch_box

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, giving the number of tracks per side (minimum 2).
REQ-002 The module SHALL have parameter MODE, default 0, where 0 selects disjoint topology and 1 selects Wilton topology.
REQ-003 The module SHALL have port prog_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port prog_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port prog_en, input, 1 bit: shift enable for the configuration chain.
REQ-006 The module SHALL have port prog_in, input, 1 bit: serial configuration data in.
REQ-007 The module SHALL have port prog_rdbk, input, 1 bit: single-cycle request to capture the active configuration for readback.
REQ-008 The module SHALL have port prog_out, output, 1 bit: serial chain data out.
REQ-009 The module SHALL have ports l_in, t_in, r_in, b_in, each an input of WIDTH bits carrying the per-side track values.
REQ-010 The module SHALL have ports l_out, t_out, r_out, b_out, each an output of WIDTH bits carrying the per-side driven values.
REQ-011 The module SHALL have ports l_oe, t_oe, r_oe, b_oe, each an output of WIDTH bits carrying the per-track drive enables.
REQ-012 The module SHALL have ports cfg_valid and cfg_err, each an output of 1 bit: configuration committed, and last commit rejected.

Function
REQ-013 Config width SHALL be N = 8*WIDTH; chain register SHALL be N+1 bits, with bit N the parity bit.
REQ-014 Config layout SHALL be sides l, t, r, b at offsets 0, 2W, 4W, 6W, with track i's 2-bit select at side offset + 2i.
REQ-015 Select encoding SHALL be: 0 = off; 1 = opposite side; 2 = next side clockwise; 3 = next side counter-clockwise (clockwise order t, r, b, l).
REQ-016 In MODE 0, every source SHALL use the same track index i.
REQ-017 In MODE 1, straight (code 1) SHALL use track i, clockwise (code 2) SHALL use track (i+1) mod WIDTH, and counter-clockwise (code 3) SHALL use track (i+WIDTH-1) mod WIDTH.
REQ-018 x_oe[i] SHALL be cfg_valid AND select != 0.
REQ-019 x_out[i] SHALL be the selected source's x_in bit, or 0 when off; x_out and x_oe are combinational from the active config register.
REQ-020 On any edge with prog_en=1, the chain SHALL shift as {chain[N-1:0], prog_in}, regardless of FSM state.
REQ-021 prog_out SHALL equal chain[N].
REQ-022 The FSM SHALL have states IDLE, SHIFT, COMMIT.
REQ-023 IDLE SHALL go to SHIFT when prog_en=1.
REQ-024 SHIFT SHALL go to COMMIT when prog_en=0, with no shift on that edge.
REQ-025 COMMIT SHALL last exactly one cycle and then go to IDLE, or to SHIFT if prog_en=1.
REQ-026 In COMMIT, if XOR of all N+1 chain bits = 0, the active config SHALL load chain[N-1:0], cfg_valid SHALL be set to 1 and cfg_err cleared; otherwise the active config SHALL be unchanged and cfg_err set to 1.
REQ-027 The commit check SHALL use the pre-shift chain value when prog_en=1 in COMMIT.
REQ-028 Commit latency SHALL be exactly 2 prog_clk edges after the first edge sampling prog_en=0.
REQ-029 prog_rdbk=1 in IDLE with prog_en=0 SHALL load chain <= {^config, config}; prog_rdbk SHALL be ignored in SHIFT or COMMIT, or when prog_en=1.
REQ-030 The active config SHALL never change outside COMMIT, so routing stays glitch-free during shifting.

Reset
REQ-031 prog_rst=1 SHALL immediately force chain=0, config=0, cfg_valid=0, cfg_err=0, FSM=IDLE, all x_oe=0, all x_out=0 and prog_out=0, including mid-shift or mid-commit.
REQ-032 After reset deasserts, no commit SHALL occur until a complete IDLE->SHIFT->COMMIT sequence.

Structure
REQ-033 A shared package SHALL hold the select codes (SEL_OFF, SEL_STRAIGHT, SEL_CW, SEL_CCW), the FSM state enum, the MODE constants, and side offset functions.
REQ-034 There SHALL be one sub-module, sb_track_mux, instantiated once per side and track, which maps a select code, MODE and index to out/oe.

Verification
REQ-035 With WIDTH=3 and MODE=0, shifting 25 bits (parity 1 first, then 24'h000001 MSB-first) and dropping prog_en SHALL yield, 2 edges later, cfg_valid=1, l_oe=3'b001 and l_out[0] following r_in[0].
REQ-036 The same stream with parity 0 SHALL yield cfg_err=1, cfg_valid unchanged, and all oe unchanged.
REQ-037 With MODE=1, config 24'h000080 with parity 1 SHALL yield t_oe[0]=1 and t_out[0] following r_in[1]; config code 3 on t[0] SHALL follow l_in[2].
REQ-038 Readback: after committing 24'h00A5C3, pulsing prog_rdbk and shifting 25 cycles SHALL present on prog_out the parity bit followed by config MSB-first.
REQ-039 Two instances chained via prog_out->prog_in with 50 bits shifted SHALL have both commit independently; asserting prog_rst at bit 12 SHALL clear all state with outputs off.
